// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE       = 4'd9;
  localparam logic [4:0] BCD_TEN        = 5'd10;
  localparam int         DEFAULT_DIGITS = 4;

endpackage

// File: rtl/bcd_serial_subtractor_addc.sv
// Combinational single-digit BCD add with carry; sums above nine wrap by ten.
module bcd_digit_addc
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  assign raw  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
  assign adj  = raw - BCD_TEN;
  assign cout = (raw > {1'b0, BCD_NINE});
  assign s    = cout ? adj[3:0] : raw[3:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A-B| in packed BCD via ten's-complement addition, with a
// second recomplement pass when the raw result is negative.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  function automatic logic has_bad_nibble(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_NINE) bad = 1'b1;
    end
    return bad;
  endfunction

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic [4*DIGITS-1:0]   a_q, b_q;
  logic [3:0]            a_nib, b_nib, d_nib;
  logic [3:0]            x_dig, y_dig, s_dig;
  logic                  cout;
  logic                  bad_in;
  logic                  at_last;

  assign bad_in  = has_bad_nibble(a) | has_bad_nibble(b);
  assign at_last = (idx == LAST);
  assign ready   = (state == IDLE);
  assign done    = (state == DONE);

  // Select the current digit; RECOMP complements the stored diff in place.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    d_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
        d_nib = diff[4*i +: 4];
      end
    end
    x_dig = (state == SUB) ? a_nib : 4'd0;
    y_dig = BCD_NINE - ((state == SUB) ? b_nib : d_nib);
  end

  bcd_digit_addc u_addc (
    .x    (x_dig),
    .y    (y_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad_in ? DONE : SUB;
      SUB:     if (at_last) state_nx = cout ? DONE : RECOMP;
      RECOMP:  if (at_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      diff  <= '0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            diff  <= '0;
            neg   <= 1'b0;
            err   <= bad_in;
            idx   <= '0;
            carry <= ~bad_in;
          end
        end
        SUB, RECOMP: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) diff[4*i +: 4] <= s_dig;
          end
          if (at_last) begin
            idx   <= '0;
            carry <= 1'b1;
            // No carry out of the top digit means B > A.
            if (state == SUB) neg <= ~cout;
          end else begin
            idx   <= idx + 1'b1;
            carry <= cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor with DIGITS=4.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] a, b;
  logic                ready, done, neg, err;
  logic [4*DIGITS-1:0] diff;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge. lat counts edges after the accept edge
  // until done is seen; an error goes straight to DONE so lat is 0 there.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] exp_diff, input logic exp_neg, input logic exp_err,
                        input int exp_lat, input bit glitch);
    int lat;
    check({tag, ".ready"}, {31'b0, ready}, 32'd1);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    lat = 0;
    while (!done && lat < 50) begin
      if (glitch && lat == 1) begin
        start = 1'b1;
        a = 16'h9999;
        b = 16'h0000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".diff"}, {16'b0, diff}, {16'b0, exp_diff});
    check({tag, ".neg"}, {31'b0, neg}, {31'b0, exp_neg});
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, {31'b0, done}, 32'd0);
    check({tag, ".hold"}, {16'b0, diff}, {16'b0, exp_diff});
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, ready}, 32'd1);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.diff", {16'b0, diff}, 32'd0);
    check("rst.neg", {31'b0, neg}, 32'd0);
    check("rst.err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("pos",    16'h0456, 16'h0123, 16'h0333, 1'b0, 1'b0, DIGITS,   1'b0);
    run_op("negv",   16'h0123, 16'h0456, 16'h0333, 1'b1, 1'b0, 2*DIGITS, 1'b0);
    run_op("zmax",   16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 2*DIGITS, 1'b0);
    run_op("maxz",   16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, DIGITS,   1'b0);
    run_op("equal",  16'h5050, 16'h5050, 16'h0000, 1'b0, 1'b0, DIGITS,   1'b0);
    run_op("badnib", 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0,        1'b0);
    run_op("borrow", 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, DIGITS,   1'b0);
    run_op("glitch", 16'h0456, 16'h0123, 16'h0333, 1'b0, 1'b0, DIGITS,   1'b1);
    // Back-to-back: run_op returns in the first IDLE cycle after done.
    run_op("b2b",    16'h0002, 16'h0010, 16'h0008, 1'b1, 1'b0, 2*DIGITS, 1'b0);

    // Abort in the middle of RECOMP.
    a = 16'h0123;
    b = 16'h0456;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (DIGITS + 2) @(posedge clk);
    #1;
    check("abort.busy", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.ready", {31'b0, ready}, 32'd1);
    check("abort.diff", {16'b0, diff}, 32'd0);
    check("abort.neg", {31'b0, neg}, 32'd0);
    seen_done = 1'b0;
    repeat (12) begin
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort.nodone", {31'b0, seen_done}, 32'd0);
    run_op("after",  16'h0500, 16'h0250, 16'h0250, 1'b0, 1'b0, DIGITS,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
